// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit for the OpenMIPS core
//
// Purpose:
//   Merges stall requests from NUM_STAGES pipeline stages into one hold vector.
//   The vector covers the PC and each inter-stage register.
//   Sequences multi-cycle pipeline flushes and supplies pc_reg with the
//   redirect PC while a flush is active.
//
// Parameters:
//   NUM_STAGES   number of pipeline stages (IF..WB); stall_o is NUM_STAGES+1 bits
//   FLUSH_CYCLES cycles flush_o stays high per accepted flush, legal range 1..15
//   ADDR_W       width of the redirect PC
//   CNT_W        width of the performance counters
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset; forces all control
//                       outputs low combinationally while asserted
//   stallreq_i     in   bit k = stage k requests a stall (0=IF, 1=ID, 2=EX ...)
//   flush_req_i    in   flush request (exception / eret / mispredict)
//   flush_pc_i     in   redirect target, sampled together with flush_req_i
//   stall_o        out  bit 0 = PC hold, bit j = hold the register feeding stage j
//   flush_o        out  clear all inter-stage registers to a bubble
//   new_pc_o       out  PC to load while flush_o is high
//   busy_o         out  high while a multi-cycle flush continues
//   stall_cycles_o out  cycles with any stall_o bit set
//   flush_count_o  out  number of accepted flush requests
//
// Build option:
//   Define PIPE_PERF_EN to build the two saturating performance counters.
//   When PIPE_PERF_EN is undefined, stall_cycles_o and flush_count_o are tied
//   to 0 and no counter flops exist.
//------------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int NUM_STAGES   = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int ADDR_W       = 32,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stallreq_i,
   input  logic                  flush_req_i,
   input  logic [ADDR_W-1:0]     flush_pc_i,
   output logic [NUM_STAGES:0]   stall_o,
   output logic                  flush_o,
   output logic [ADDR_W-1:0]     new_pc_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      stall_cycles_o,
   output logic [CNT_W-1:0]      flush_count_o
);

   typedef enum logic {
      ST_RUN,
      ST_FLUSH
   } state_t;

   // The request cycle is the first flush cycle, so the continuation counter
   // loads with one fewer cycle.
   localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam bit         MULTI     = (FLUSH_CYCLES > 1);

   state_t              state, state_nxt;
   logic [3:0]          fcnt, fcnt_nxt;
   logic [ADDR_W-1:0]   pc_q, pc_nxt;
   logic [NUM_STAGES:0] stall_dec;
   logic                req_or;

   //---------------------------------------------------------------------------
   // Stall decode.
   // The highest requesting stage k determines the vector: stall_dec[k+1:0] is
   // all ones and the bits above it are zero. For each bit j >= 1 this means
   // stall_dec[j] = OR of stallreq_i[NUM_STAGES-1 : j-1]. A running OR is
   // built from the top stage down. stall_dec[0] (PC hold) is then set
   // whenever any stage stalls.
   //---------------------------------------------------------------------------
   always_comb begin
      req_or    = 1'b0;
      stall_dec = '0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         req_or         = req_or | stallreq_i[j];
         stall_dec[j+1] = req_or;
      end
      stall_dec[0] = req_or;
   end

   //---------------------------------------------------------------------------
   // State register. Reset is synchronous and has the highest priority.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every flop samples values from
      // before the edge.
      if (rst) begin
         state <= ST_RUN;
         fcnt  <= '0;
         pc_q  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         pc_q  <= pc_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next state and outputs.
   // Priority order: rst, then flush_req_i, then an active flush, then stalls.
   // In RUN the outputs are combinational, which gives zero-latency stall and
   // flush. Only the continuation of a flush is registered.
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch, so that no path
      // leaves a signal unassigned and infers a latch.
      state_nxt = state;
      fcnt_nxt  = fcnt;
      pc_nxt    = pc_q;
      stall_o   = '0;
      flush_o   = 1'b0;
      new_pc_o  = '0;
      busy_o    = 1'b0;

      if (!rst) begin
         if (flush_req_i) begin
            // A new request always wins. Inside FLUSH it restarts the
            // sequence and shows the new target in the same cycle.
            flush_o  = 1'b1;
            new_pc_o = flush_pc_i;
            busy_o   = (state == ST_FLUSH);
            if (MULTI) begin
               state_nxt = ST_FLUSH;
               fcnt_nxt  = FCNT_LOAD;
               pc_nxt    = flush_pc_i;
            end else begin
               state_nxt = ST_RUN;
               fcnt_nxt  = '0;
            end
         end else if (state == ST_FLUSH) begin
            // Stall requests are ignored while the pipeline is being cleared.
            flush_o  = 1'b1;
            busy_o   = 1'b1;
            new_pc_o = pc_q;
            if (fcnt <= 4'd1) begin
               state_nxt = ST_RUN;
               fcnt_nxt  = '0;
            end else begin
               fcnt_nxt = fcnt - 4'd1;
            end
         end else begin
            stall_o = stall_dec;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Performance counters (saturating, cleared on rst).
   // stall_o and flush_o are already low during reset. The else branch
   // therefore counts only non-reset cycles.
   //---------------------------------------------------------------------------
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((|stall_o) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush_req_i && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cycles_o = stall_cnt;
   assign flush_count_o  = flush_cnt;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule
